// File: rtl/shift_seq_ctrl.sv
// Serialises a 4-bit word MSB-first into an external shift register, one sr_en pulse every div+1 cycles, then captures and checks sr_q.
// Latency with div=0: 4 shift cycles + CAPTURE + DONE; in_ready low until the result is taken (out_ready stalls DONE).
module shift_seq_ctrl #(
  parameter int DIV_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [3:0]       in_data,
  output logic             in_ready,
  input  logic [DIV_W-1:0] div,
  output logic             sr_en,
  output logic             sr_d,
  input  logic [3:0]       sr_q,
  output logic             out_valid,
  output logic [3:0]       out_data,
  output logic             out_err,
  input  logic             out_ready,
  output logic             busy
);

  typedef enum logic [1:0] {IDLE, SHIFT, CAPTURE, DONE} state_e;

  state_e           state_q, state_d;
  logic [3:0]       hold_q, hold_d;
  logic [DIV_W-1:0] div_l_q, div_l_d;
  logic [DIV_W-1:0] presc_q, presc_d;
  logic [1:0]       bitcnt_q, bitcnt_d;
  logic [3:0]       out_data_q, out_data_d;
  logic             out_err_q, out_err_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      hold_q     <= '0;
      div_l_q    <= '0;
      presc_q    <= '0;
      bitcnt_q   <= '0;
      out_data_q <= '0;
      out_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      hold_q     <= hold_d;
      div_l_q    <= div_l_d;
      presc_q    <= presc_d;
      bitcnt_q   <= bitcnt_d;
      out_data_q <= out_data_d;
      out_err_q  <= out_err_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    hold_d     = hold_q;
    div_l_d    = div_l_q;
    presc_d    = presc_q;
    bitcnt_d   = bitcnt_q;
    out_data_d = out_data_q;
    out_err_d  = out_err_q;
    in_ready   = 1'b0;
    sr_en      = 1'b0;
    sr_d       = 1'b0;
    out_valid  = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          hold_d   = in_data;
          div_l_d  = div;
          presc_d  = div;
          bitcnt_d = 2'd0;
          state_d  = SHIFT;
        end
      end
      SHIFT: begin
        if (presc_q != '0) begin
          presc_d = presc_q - DIV_W'(1);
        end else begin
          // Pulse cycle: the latched period reloads so later div changes are ignored
          sr_en    = 1'b1;
          sr_d     = hold_q[2'd3 - bitcnt_q];
          bitcnt_d = bitcnt_q + 2'd1;
          presc_d  = div_l_q;
          if (bitcnt_q == 2'd3) state_d = CAPTURE;
        end
      end
      CAPTURE: begin
        out_data_d = sr_q;
        out_err_d  = (sr_q != hold_q);
        state_d    = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy     = (state_q != IDLE);
  assign out_data = out_data_q;
  assign out_err  = out_err_q;

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// Directed bench: external shift register model (optional stuck readback bit), cycle-exact pulse/latency checks.
module tb_shift_seq_ctrl;
  localparam int DIV_W = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             in_valid = 1'b0;
  logic [3:0]       in_data = 4'h0;
  logic             in_ready;
  logic [DIV_W-1:0] div = '0;
  logic             sr_en;
  logic             sr_d;
  logic [3:0]       sr_q;
  logic             out_valid;
  logic [3:0]       out_data;
  logic             out_err;
  logic             out_ready = 1'b0;
  logic             busy;

  logic [3:0] sr_reg = 4'h0;
  logic       stuck = 1'b0;
  logic [3:0] last_out = 4'h0;
  logic       last_err = 1'b0;
  int         n_chk = 0;
  int         n_err = 0;

  shift_seq_ctrl #(.DIV_W(DIV_W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .div(div), .sr_en(sr_en), .sr_d(sr_d), .sr_q(sr_q), .out_valid(out_valid),
    .out_data(out_data), .out_err(out_err), .out_ready(out_ready), .busy(busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (sr_en) sr_reg <= {sr_reg[2:0], sr_d};
  assign sr_q = stuck ? (sr_reg & 4'b1011) : sr_reg;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_in_ready"}, in_ready, 1);
    chk({tag, "_sr_en"}, sr_en, 0);
    chk({tag, "_sr_d"}, sr_d, 0);
    chk({tag, "_out_valid"}, out_valid, 0);
    chk({tag, "_out_data"}, out_data, 0);
    chk({tag, "_out_err"}, out_err, 0);
    chk({tag, "_busy"}, busy, 0);
  endtask

  // Offset 0 is the accepting cycle; pulses due at k*(dv+1), CAPTURE at 4P+1, DONE from 4P+2.
  task automatic do_xfer(input logic [3:0] d, input logic [DIV_W-1:0] dv, input logic [3:0] exp_out,
                         input logic exp_err, input int rdy_delay, input logic keep_valid, input string tag);
    int p;
    int k;
    logic hit;
    p = int'(dv) + 1;
    @(negedge clk);
    chk({tag, "_idle_in_ready"}, in_ready, 1);
    chk({tag, "_idle_busy"}, busy, 0);
    chk({tag, "_idle_keep_data"}, out_data, last_out);
    chk({tag, "_idle_keep_err"}, out_err, last_err);
    in_valid = 1'b1;
    in_data  = d;
    div      = dv;
    for (int off = 1; off <= 4 * p; off++) begin
      @(negedge clk);
      in_valid = keep_valid;
      if (off == 4) div = '0;
      hit = (off % p) == 0;
      k = off / p;
      chk($sformatf("%s_sr_en_o%0d", tag, off), sr_en, hit);
      chk($sformatf("%s_sr_d_o%0d", tag, off), sr_d, hit ? d[4 - k] : 1'b0);
      chk($sformatf("%s_shift_in_ready_o%0d", tag, off), in_ready, 0);
    end
    @(negedge clk);
    chk({tag, "_cap_sr_en"}, sr_en, 0);
    chk({tag, "_cap_out_valid"}, out_valid, 0);
    chk({tag, "_cap_busy"}, busy, 1);
    @(negedge clk);
    out_ready = (rdy_delay == 0);
    chk({tag, "_done_valid"}, out_valid, 1);
    chk({tag, "_done_data"}, out_data, exp_out);
    chk({tag, "_done_err"}, out_err, exp_err);
    chk({tag, "_done_in_ready"}, in_ready, 0);
    for (int i = 1; i <= rdy_delay; i++) begin
      @(negedge clk);
      chk($sformatf("%s_stall_valid%0d", tag, i), out_valid, 1);
      chk($sformatf("%s_stall_data%0d", tag, i), out_data, exp_out);
      chk($sformatf("%s_stall_err%0d", tag, i), out_err, exp_err);
      chk($sformatf("%s_stall_in_ready%0d", tag, i), in_ready, 0);
      chk($sformatf("%s_stall_busy%0d", tag, i), busy, 1);
      out_ready = (i == rdy_delay);
    end
    last_out = exp_out;
    last_err = exp_err;
  endtask

  initial begin
    #1;
    chk_reset_outputs("por");
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;

    do_xfer(4'b1011, 4'd0,  4'b1011, 1'b0, 0, 1'b0, "d0_1011");
    do_xfer(4'b0110, 4'd2,  4'b0110, 1'b0, 0, 1'b0, "d2_0110");
    stuck = 1'b1;
    do_xfer(4'b1111, 4'd0,  4'b1011, 1'b1, 0, 1'b0, "stuck");
    @(negedge clk);
    stuck = 1'b0;
    chk("stuck_idle_keep_err", out_err, 1);
    do_xfer(4'b0101, 4'd1,  4'b0101, 1'b0, 5, 1'b1, "stall");
    do_xfer(4'b1100, 4'd15, 4'b1100, 1'b0, 0, 1'b0, "dmax");

    // Abort mid-transfer: word accepted with div=1, reset lands after the 2nd pulse
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = 4'b1010;
    div      = 4'd1;
    for (int off = 1; off <= 4; off++) begin
      @(negedge clk);
      in_valid = 1'b0;
      chk($sformatf("abort_sr_en_o%0d", off), sr_en, (off % 2) == 0);
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk_reset_outputs("arst");
    @(negedge clk);
    rst = 1'b1;
    last_out = 4'h0;
    last_err = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk($sformatf("post_rst_sr_en%0d", i), sr_en, 0);
      chk($sformatf("post_rst_busy%0d", i), busy, 0);
    end
    do_xfer(4'b0001, 4'd0, 4'b0001, 1'b0, 0, 1'b0, "fresh");
    @(negedge clk);
    chk("final_in_ready", in_ready, 1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
